serial_subtractor_top: RTL and testbench

- Bit-serial subtractor; the inverse of the team's serial adder.
- Takes a (WIDTH+1)-bit minuend and a WIDTH-bit subtrahend in parallel and computes their difference one bit per clock, LSB first, using a borrow flip-flop.
- Returns a (WIDTH+1)-bit difference plus a final borrow flag.
- Sits beside the serial adder: feeding it the adder's result and one adder operand recovers the other operand.

---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor_top.sv | 92 +++++++++
 tb/tb_serial_subtractor_top.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding, default width
// and the bit-counter sizing helper.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter must hold 0..width, since the minuend is one bit wider than the subtrahend.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with the borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_top.sv
// Bit-serial subtractor: latches a (WIDTH+1)-bit minuend and a WIDTH-bit subtrahend,
// then produces their difference LSB first, one bit per clock, through a borrow flip-flop.
module serial_subtractor_top
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH:0]   data_m,
    input  logic [WIDTH-1:0] data_s,
    output logic [WIDTH:0]   difference,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH:0]   b_reg;
    logic [WIDTH:0]   diff_reg;
    logic             borrow_ff;
    logic [CNT_W-1:0] cnt;
    logic             d_bit;
    logic             bout_bit;

    full_subtractor u_cell (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .bin  (borrow_ff),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // NOTE: every branch of a combinational block must assign its outputs; the default
    // at the top keeps the tool from inferring a latch for unlisted cases.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (cnt == LAST_BIT) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update
    // from the same pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            diff_reg  <= '0;
            borrow_ff <= 1'b0;
            cnt       <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg     <= data_m;
                        b_reg     <= {1'b0, data_s};
                        diff_reg  <= '0;
                        borrow_ff <= 1'b0;
                        cnt       <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_reg     <= {1'b0, a_reg[WIDTH:1]};
                    b_reg     <= {1'b0, b_reg[WIDTH:1]};
                    diff_reg  <= {d_bit, diff_reg[WIDTH:1]};
                    borrow_ff <= bout_bit;
                    cnt       <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // The borrow FF only moves during SHIFT, so after the last bit it holds the final borrow.
    assign difference = diff_reg;
    assign borrow     = borrow_ff;
    assign busy       = (state == ST_SHIFT);
    assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor_top.sv
// Self-checking bench for serial_subtractor_top: directed vector table plus
// hand-written sequences for start-while-busy, reset mid-operation and a round trip.
module tb_serial_subtractor_top;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W:0]   data_m;
    logic [W-1:0] data_s;
    logic [W:0]   difference;
    logic         borrow;
    logic         busy;
    logic         done;

    int checks;
    int failures;

    serial_subtractor_top #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_m     (data_m),
        .data_s     (data_s),
        .difference (difference),
        .borrow     (borrow),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W:0]   m;
        logic [W-1:0] s;
        logic [W:0]   exp_d;
        logic         exp_b;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one operation starting in the current cycle (cycle 0, IDLE) and returns
    // the cycle of the first done pulse (-1 on timeout), busy cycles seen and the result.
    // Leaves the bench in the cycle after done.
    task automatic run_op(input logic [W:0] m, input logic [W-1:0] s,
                          output int done_cyc, output int busy_cnt,
                          output logic [W:0] d, output logic b);
        done_cyc = -1;
        busy_cnt = 0;
        d = '0;
        b = 1'b0;
        data_m = m;
        data_s = s;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = cyc;
                d = difference;
                b = borrow;
                tick();
                break;
            end
            tick();
        end
    endtask

    vec_t vecs[6];
    int   done_cyc;
    int   busy_cnt;
    int   done_seen;
    logic [W:0] d_res;
    logic       b_res;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int   rt_bad;

    initial begin
        checks   = 0;
        failures = 0;
        rst    = 1'b1;
        start  = 1'b0;
        data_m = '0;
        data_s = '0;

        vecs[0] = '{m: 9'd300, s: 8'd45,  exp_d: 9'd255, exp_b: 1'b0};
        vecs[1] = '{m: 9'd10,  s: 8'd20,  exp_d: 9'h1F6, exp_b: 1'b1};
        vecs[2] = '{m: 9'd0,   s: 8'd0,   exp_d: 9'd0,   exp_b: 1'b0};
        vecs[3] = '{m: 9'd511, s: 8'd255, exp_d: 9'd256, exp_b: 1'b0};
        vecs[4] = '{m: 9'd0,   s: 8'd255, exp_d: 9'd257, exp_b: 1'b1};
        vecs[5] = '{m: 9'd300, s: 8'd100, exp_d: 9'd200, exp_b: 1'b0};

        @(negedge clk);
        tick();
        check("reset_busy",   32'(busy),       0);
        check("reset_done",   32'(done),       0);
        check("reset_diff",   32'(difference), 0);
        check("reset_borrow", 32'(borrow),     0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].m, vecs[i].s, done_cyc, busy_cnt, d_res, b_res);
            check($sformatf("vec%0d_done_cycle", i), 32'(done_cyc), 10);
            check($sformatf("vec%0d_busy_cycles", i), 32'(busy_cnt), 9);
            check($sformatf("vec%0d_diff", i), 32'(d_res), 32'(vecs[i].exp_d));
            check($sformatf("vec%0d_borrow", i), 32'(b_res), 32'(vecs[i].exp_b));
        end
        // Result holds in IDLE after done.
        check("hold_diff",   32'(difference), 200);
        check("hold_done",   32'(done),       0);

        // start while busy (cycle 3) and in DONE (cycle 10) is ignored; cycle 11 is accepted.
        data_m = 9'd300; data_s = 8'd45; start = 1'b1;
        tick();                                  // cycle 1
        start = 1'b0;
        tick();                                  // cycle 2
        tick();                                  // cycle 3
        data_m = 9'd5; data_s = 8'd1; start = 1'b1;
        tick();                                  // cycle 4
        start = 1'b0;
        done_seen = 0;
        for (int c = 4; c < 10; c++) begin
            if (done) done_seen++;
            tick();
        end                                      // now cycle 10
        check("busy_start_no_early_done", 32'(done_seen), 0);
        check("busy_start_done_c10", 32'(done), 1);
        check("busy_start_diff", 32'(difference), 255);
        check("busy_start_borrow", 32'(borrow), 0);
        data_m = 9'd5; data_s = 8'd1; start = 1'b1;
        tick();                                  // cycle 11
        check("done_start_ignored_busy", 32'(busy), 0);
        check("done_start_ignored_done", 32'(done), 0);
        check("done_start_ignored_diff", 32'(difference), 255);
        data_m = 9'd7; data_s = 8'd2;            // start still high: accepted here
        tick();                                  // cycle 12
        start = 1'b0;
        check("c11_start_accepted", 32'(busy), 1);
        done_seen = 0;
        done_cyc  = -1;
        for (int c = 12; c <= 40; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            tick();
        end
        check("c11_done_cycle", 32'(done_cyc), 21);
        check("c11_diff", 32'(difference), 5);
        tick();

        // Reset in cycle 5 of an operation.
        data_m = 9'd300; data_s = 8'd45; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();      // cycle 5
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy",   32'(busy),       0);
        check("midrst_done",   32'(done),       0);
        check("midrst_diff",   32'(difference), 0);
        check("midrst_borrow", 32'(borrow),     0);
        run_op(9'd300, 8'd45, done_cyc, busy_cnt, d_res, b_res);
        check("post_rst_done_cycle", 32'(done_cyc), 10);
        check("post_rst_diff", 32'(d_res), 255);
        check("post_rst_borrow", 32'(b_res), 0);

        // rst wins over start in the same cycle.
        data_m = 9'd9; data_s = 8'd3; rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_over_start_busy", 32'(busy), 0);
        tick();
        check("rst_over_start_idle", 32'(busy), 0);

        // Round trip with a serial adder modelled as plain 9-bit addition.
        rt_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom_range(255, 0));
            rb = W'($urandom_range(255, 0));
            run_op({1'b0, ra} + {1'b0, rb}, rb, done_cyc, busy_cnt, d_res, b_res);
            checks++;
            if (done_cyc != 10 || d_res !== {1'b0, ra} || b_res !== 1'b0) begin
                failures++;
                rt_bad++;
                if (rt_bad <= 5)
                    $display("FAIL roundtrip a=%0d b=%0d: got diff=%0d borrow=%0d done_cyc=%0d expected diff=%0d borrow=0 done_cyc=10",
                             ra, rb, d_res, b_res, done_cyc, ra);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
